// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared widths, limits and FSM encoding for the sequential binary-to-BCD converter.
package bin2bcd_pkg;
    localparam int BIN_W   = 14;
    localparam int DIGITS  = 4;
    localparam int MAX_VAL = 9999;
    localparam int BCD_W   = 4 * DIGITS;
    localparam int CNT_W   = $clog2(BIN_W + 1);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/bin2bcd_add3.sv
// bcd_add3: shift-add-3 digit corrector, bumps any digit >=5 so the next left shift carries correctly.
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 14-bit binary to 4-digit packed BCD, one bit per clock, saturating at 9999.
module bin2bcd_seq
    import bin2bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o,
    output logic             ovf_o
);
    state_t           r_state, w_next;
    logic [BCD_W-1:0] r_acc, w_adj, r_bcd;
    logic [BIN_W-1:0] r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_flag, r_ovf, r_busy, r_done;
    logic             w_load, w_shift, w_cap, w_big;

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        bcd_add3 u_add3 (.d_i(r_acc[4*d +: 4]), .d_o(w_adj[4*d +: 4]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Unused code 3 falls through to IDLE.
    always_comb begin
        w_next = (r_state == IDLE)  ? (start_i ? SHIFT : IDLE) :
                 (r_state == SHIFT) ? ((r_cnt == CNT_W'(1)) ? DONE : SHIFT) :
                                      IDLE;
    end

    always_comb begin
        w_load  = (r_state == IDLE) && start_i;
        w_shift = (r_state == SHIFT);
        w_cap   = (r_state == DONE);
        w_big   = bin_i > BIN_W'(MAX_VAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_op       <= '0;
            r_cnt      <= '0;
            r_ovf_flag <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_load) begin
                r_op       <= w_big ? BIN_W'(MAX_VAL) : bin_i;
                r_ovf_flag <= w_big;
                r_acc      <= '0;
                r_cnt      <= CNT_W'(BIN_W);
            end else if (w_shift) begin
                {r_acc, r_op} <= {w_adj[BCD_W-2:0], r_op, 1'b0};
                r_cnt         <= r_cnt - CNT_W'(1);
            end
            if (w_cap) begin
                r_bcd <= r_acc;
                r_ovf <= r_ovf_flag;
            end
            r_done <= w_cap;
            r_busy <= (w_next != IDLE);
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign bcd_o  = r_bcd;
    assign ovf_o  = r_ovf;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed checks of latency, saturation, handshake and reset abort for bin2bcd_seq.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [13:0] bin_i = '0;
    logic        busy_o, done_o, ovf_o;
    logic [15:0] bcd_o;
    int          total = 0;
    int          bad = 0;

    bin2bcd_seq dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .bin_i(bin_i),
        .busy_o(busy_o), .done_o(done_o), .bcd_o(bcd_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_i = 1'b0;
        bin_i = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({busy_o, done_o, ovf_o, bcd_o} !== 19'd0) begin
                bad++;
                $display("FAIL reset_idle cyc %0d: got busy=%b done=%b ovf=%b bcd=%h want all 0", i, busy_o, done_o, ovf_o, bcd_o);
            end
        end
    endtask

    task automatic test_basic;
        int busy_cnt = 0;
        bin_i = 14'd1892;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 40 && !done_o; i++) begin
            if (busy_o) busy_cnt++;
            if (i < 15) tick();
            else break;
        end
        total++;
        if (done_o !== 1'b1) begin
            bad++;
            $display("FAIL basic_latency: got done=%b after 15 clocks want 1", done_o);
        end
        total++;
        if (busy_cnt != 15) begin
            bad++;
            $display("FAIL basic_busy: got %0d busy cycles want 15", busy_cnt);
        end
        total++;
        if (bcd_o !== 16'h1892 || ovf_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_value: got bcd=%h ovf=%b busy=%b want 1892 0 0", bcd_o, ovf_o, busy_o);
        end
        tick();
        total++;
        if (done_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_pulse: got done=%b one cycle later want 0", done_o);
        end
    endtask

    task automatic test_values;
        logic [13:0] vin [7] = '{14'd1, 14'd10, 14'd99, 14'd100, 14'd1000, 14'd8191, 14'd10000};
        logic [15:0] vexp [7] = '{16'h0001, 16'h0010, 16'h0099, 16'h0100, 16'h1000, 16'h8191, 16'h9999};
        logic        vovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int k = 0; k < 7; k++) begin
            bin_i = vin[k];
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            wait_done(lat);
            total++;
            if (lat != 15 || bcd_o !== vexp[k] || ovf_o !== vovf[k]) begin
                bad++;
                $display("FAIL value_%0d: got lat=%0d bcd=%h ovf=%b want 15 %h %b", vin[k], lat, bcd_o, ovf_o, vexp[k], vovf[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bin_i = 14'd0;
        start_i = 1'b1;
        tick();
        bin_i = 14'd9999;
        wait_done(lat);
        total++;
        if (lat != 15 || bcd_o !== 16'h0000 || ovf_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_zero: got lat=%0d bcd=%h ovf=%b want 15 0000 0", lat, bcd_o, ovf_o);
        end
        tick();
        total++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_restart1: got busy=%b done=%b want 1 0", busy_o, done_o);
        end
        bin_i = 14'd9;
        wait_done(lat);
        total++;
        if (lat != 15 || bcd_o !== 16'h9999 || ovf_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_max: got lat=%0d bcd=%h ovf=%b want 15 9999 0", lat, bcd_o, ovf_o);
        end
        tick();
        total++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_restart2: got busy=%b done=%b want 1 0", busy_o, done_o);
        end
        start_i = 1'b0;
        wait_done(lat);
        total++;
        if (lat != 15 || bcd_o !== 16'h0009 || ovf_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_nine: got lat=%0d bcd=%h ovf=%b want 15 0009 0", lat, bcd_o, ovf_o);
        end
        tick();
    endtask

    task automatic test_ovf;
        int lat;
        bin_i = 14'd12000;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(lat);
        total++;
        if (lat != 15 || bcd_o !== 16'h9999 || ovf_o !== 1'b1) begin
            bad++;
            $display("FAIL ovf_12000: got lat=%0d bcd=%h ovf=%b want 15 9999 1", lat, bcd_o, ovf_o);
        end
        bin_i = 14'd42;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        total++;
        if (bcd_o !== 16'h9999 || ovf_o !== 1'b1) begin
            bad++;
            $display("FAIL ovf_hold: got bcd=%h ovf=%b mid-shift want 9999 1", bcd_o, ovf_o);
        end
        wait_done(lat);
        total++;
        if (bcd_o !== 16'h0042 || ovf_o !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got bcd=%h ovf=%b want 0042 0", bcd_o, ovf_o);
        end
        bin_i = 14'd16383;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(lat);
        total++;
        if (bcd_o !== 16'h9999 || ovf_o !== 1'b1) begin
            bad++;
            $display("FAIL ovf_16383: got bcd=%h ovf=%b want 9999 1", bcd_o, ovf_o);
        end
        tick();
    endtask

    task automatic test_ignore;
        int extra = 0;
        bin_i = 14'd512;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        bin_i = 14'd7;
        repeat (2) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (11) tick();
        total++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL ignore_done_state: got busy=%b done=%b before DONE edge want 1 0", busy_o, done_o);
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        total++;
        if (done_o !== 1'b1 || bcd_o !== 16'h0512) begin
            bad++;
            $display("FAIL ignore_result: got done=%b bcd=%h want 1 0512", done_o, bcd_o);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy_o || done_o) extra++;
        end
        total++;
        if (extra != 0 || bcd_o !== 16'h0512) begin
            bad++;
            $display("FAIL ignore_no_restart: got %0d busy/done cycles bcd=%h want 0 0512", extra, bcd_o);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        bin_i = 14'd4321;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy_o, done_o, ovf_o, bcd_o} !== 19'd0) begin
            bad++;
            $display("FAIL abort_async: got busy=%b done=%b ovf=%b bcd=%h want all 0", busy_o, done_o, ovf_o, bcd_o);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        wait_done(lat);
        total++;
        if (lat != -1 || bcd_o !== 16'h0000) begin
            bad++;
            $display("FAIL abort_no_done: got lat=%0d bcd=%h want no done 0000", lat, bcd_o);
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(lat);
        total++;
        if (lat != 15 || bcd_o !== 16'h4321 || ovf_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_rerun: got lat=%0d bcd=%h ovf=%b want 15 4321 0", lat, bcd_o, ovf_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_back_to_back();
        test_ovf();
        test_ignore();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
